// File: rtl/irq_controller_n_if.sv
// irq_controller_n_if: core/CSR and peripheral signal bundle of the interrupt controller.
`default_nettype none

interface irq_controller_n_if #(
    parameter int N_IRQ = 16
);
    logic             exception_i;
    logic [N_IRQ-1:0] mie_i;
    logic             mret_i;
    logic [N_IRQ-1:0] irq_req_i;
    logic             irq_o;
    logic [31:0]      irq_cause_o;
    logic             irq_ret_o;
    logic [N_IRQ-1:0] irq_ack_o;
    logic [N_IRQ-1:0] irq_pending_o;

    modport slave (
        input  exception_i, mie_i, mret_i, irq_req_i,
        output irq_o, irq_cause_o, irq_ret_o, irq_ack_o, irq_pending_o
    );

    modport master (
        output exception_i, mie_i, mret_i, irq_req_i,
        input  irq_o, irq_cause_o, irq_ret_o, irq_ack_o, irq_pending_o
    );
endinterface

`default_nettype wire

// File: rtl/irq_controller_n.sv
// irq_controller_n: N-channel fixed-priority interrupt controller (edge/level per channel).
// Revision: 1.0
`default_nettype none

module irq_controller_n #(
    parameter int               N_IRQ      = 16,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]      CAUSE_BASE = 32'h10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    irq_controller_n_if.slave  bus
);
    localparam int         IDX_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [N_IRQ-1:0] r_req_prev;
    logic [N_IRQ-1:0] r_edge_pend;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_pending;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_win_onehot;
    logic [N_IRQ-1:0] w_clear;
    logic [IDX_W-1:0] w_win_idx;
    logic [30:0]      w_cause_low;
    logic             w_accept;
    logic             w_ret;
    logic             r_irq;
    logic [N_IRQ-1:0] r_ack;
    logic [31:0]      r_cause;

    assign w_rise     = bus.irq_req_i & ~r_req_prev;
    assign w_pending  = (EDGE_MASK & r_edge_pend) | (~EDGE_MASK & bus.irq_req_i);
    assign w_eligible = w_pending & bus.mie_i;

    // Lowest set index wins; two's-complement trick isolates that bit.
    always_comb begin
        w_win_idx = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_win_idx = IDX_W'(k);
            end
        end
    end

    assign w_win_onehot = w_eligible & (~w_eligible + N_IRQ'(1));
    assign w_cause_low  = 31'(CAUSE_BASE) + 31'(w_win_idx);
    assign w_clear      = w_accept ? w_win_onehot : '0;

    // History resets to all ones so lines already high at release raise nothing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_req_prev  <= '1;
            r_edge_pend <= '0;
        end else begin
            r_req_prev  <= bus.irq_req_i;
            r_edge_pend <= EDGE_MASK & ((r_edge_pend & ~w_clear) | w_rise);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_next = S_BUSY;
            S_BUSY:  if (bus.mret_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_ret    = 1'b0;
        case (r_state)
            S_IDLE:  w_accept = (|w_eligible) && !bus.exception_i;
            S_BUSY:  w_ret    = bus.mret_i;
            default: ;
        endcase
    end

    // Cause holds across BUSY and idle periods until the next acceptance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_irq   <= 1'b0;
            r_ack   <= '0;
            r_cause <= '0;
        end else begin
            r_irq <= w_accept;
            r_ack <= w_accept ? w_win_onehot : '0;
            if (w_accept) begin
                r_cause <= {1'b1, w_cause_low};
            end
        end
    end

    assign bus.irq_o         = r_irq;
    assign bus.irq_ack_o     = r_ack;
    assign bus.irq_cause_o   = r_cause;
    assign bus.irq_ret_o     = w_ret;
    assign bus.irq_pending_o = w_pending;

endmodule

`default_nettype wire

// File: doc/irq_controller_n.md
Name: irq_controller_n

Overview:
Parametrised multi-channel interrupt controller for the single-core RV32 processor system, placed between peripheral interrupt lines and the core/CSR block. It generalises the single-line controller to N_IRQ sources, with per-channel edge or level mode, fixed priority, masking, pending status and per-channel acknowledge. It drives the trap request, the mcause value and the interrupt-return strobe to the core.

Parameters:
N_IRQ, 16, number of interrupt channels (1..32)
EDGE_MASK, {N_IRQ{1'b0}}, bit k=1: channel k is edge-triggered (rising); 0: level-triggered
CAUSE_BASE, 32'h10, mcause code of channel 0; CAUSE_BASE+N_IRQ-1 must be < 2^31

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-low
exception_i  in  1  core is taking a synchronous exception this cycle
mie_i  in  N_IRQ  per-channel enable mask from CSR
mret_i  in  1  core is executing mret this cycle
irq_req_i  in  N_IRQ  peripheral request lines, already synchronous to clk_i
irq_o  out  1  trap request to core, one-cycle pulse
irq_cause_o  out  32  mcause value for the accepted interrupt
irq_ret_o  out  1  interrupt-return strobe to core
irq_ack_o  out  N_IRQ  one-hot acknowledge to the serviced peripheral, pulses with irq_o
irq_pending_o  out  N_IRQ  raw pending vector before masking (status)

Behaviour:
- Reset (rst_i=0, async): state=IDLE; edge-pending regs=0; edge-history regs=all ones, so a line already high at reset release raises no request; irq_o=0, irq_ack_o=0, irq_cause_o=0, irq_ret_o=0.
- Pending: edge channel k: set on irq_req_i[k] rising (prev=0, now=1). Cleared on the clock edge at which k is accepted. Set wins over clear. A second edge while already pending merges, with no count. Level channel k: pending = irq_req_i[k] combinationally, no latch. irq_pending_o reflects this vector.
- Eligible = pending & mie_i. Winner = lowest set index (channel 0 highest priority).
- FSM states IDLE and BUSY.
- IDLE -> BUSY on a clock edge where eligible != 0 and exception_i=0. Registered outputs at that same edge:
  - irq_o=1 and irq_ack_o=one-hot(winner) for exactly 1 cycle.
  - irq_cause_o = {1'b1, 31'(CAUSE_BASE+winner)}.
- Latency: request visible at cycle t gives irq_o high in cycle t+1.
- exception_i=1 in IDLE: no acceptance that cycle; pending is retained.
- BUSY: no new acceptance. Edges keep latching. irq_cause_o holds until the next acceptance.
- irq_ret_o = mret_i & (state==BUSY), combinational. BUSY -> IDLE on a clock edge with mret_i=1.
- mret_i in IDLE (exception return): irq_ret_o=0, no state change.
- mret and a pending request in the same cycle t: IDLE at t+1, evaluation at t+1, irq_o at t+2.
- Masked pending edges persist and are serviced once mie_i enables them.
- A level line dropping before acceptance cancels its request.
- Reset in BUSY: immediate IDLE, all pending cleared, outputs to reset values.

Test Plan:
- N_IRQ=16, all level, mie_i=16'hFFFF; raise irq_req_i[0] at cycle 20 -> irq_o=1 at cycle 21 only, irq_cause_o=32'h8000_0010, irq_ack_o=16'h0001; mret_i 1 cycle -> irq_ret_o=1 in that cycle, then IDLE.
- Set irq_req_i=16'h0120 simultaneously -> channel 5 first (cause 32'h8000_0015, ack 16'h0020); after mret with line 5 low, channel 8 follows (cause 32'h8000_0018) two cycles after the mret cycle.
- EDGE_MASK=16'h0004; 1-cycle pulse on line 2 while BUSY -> irq_pending_o[2]=1 held; after mret, accepted with cause 32'h8000_0012 and pending cleared.
- mie_i=0 with edge on line 2 -> irq_o stays 0, pending stays 1; set mie_i[2]=1 -> irq_o next cycle.
- exception_i=1 in the cycle the request appears -> no irq_o; exception_i drops -> irq_o on the following cycle; mret_i in IDLE -> irq_ret_o=0.
- rst_i low during BUSY with an edge pending -> all outputs 0 immediately; line held high through release -> no irq_o.
